// File: rtl/instr_prefetch_queue_pkg.sv
// Shared definitions for the instruction prefetch queue.
//   - Field slices of the 16-bit instruction word (opcode, flag bit, immediate).
//   - Fetch FSM state encoding.
package instr_prefetch_queue_pkg;

  localparam int INSTR_W  = 16;
  localparam int OP_MSB   = 15;
  localparam int OP_LSB   = 11;
  localparam int FLAG_BIT = 10;
  localparam int IMM_W    = 10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DROP = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/instr_prefetch_queue_iq_fifo.sv
// iq_fifo: circular buffer holding fetched entries for the prefetch queue.
// Ports:
//   clk_i, rst_ni   clock, async active-low reset
//   clear_i         empty the buffer (wins over push/pop)
//   push_i/wdata_i  write an entry at the tail
//   pop_i           drop the head entry (caller guarantees non-empty)
//   head_o          head entry, all zero when empty
//   count_o         number of stored entries
module iq_fifo #(
  parameter int DW    = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     clear_i,
  input  logic                     push_i,
  input  logic [DW-1:0]            wdata_i,
  input  logic                     pop_i,
  output logic [DW-1:0]            head_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DW-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;

  // Storage needs no reset: head_o is masked while the buffer is empty.
  always_ff @(posedge clk_i) begin
    if (push_i && !clear_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (clear_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop_i)  rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_q + CW'(push_i) - CW'(pop_i);
    end
  end

  assign head_o  = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
  assign count_o = count_q;

endmodule

// File: rtl/instr_prefetch_queue.sv
// instr_prefetch_queue: fetches instruction words from imem, buffers up to
// DEPTH of them and presents the head to the decoder on a ready/take handshake.
// A flush discards everything (including an in-flight fetch) and redirects.
// Ports:
//   CLK, Reset_n               clock, async active-low reset
//   imem_req/imem_addr         one-cycle fetch request and its word address
//   imem_rvalid/imem_rdata     fetch response (exactly one per request)
//   flush/flush_addr           discard queue, restart fetching at flush_addr
//   instr_ready/instr_take     head valid / head consumed this cycle
//   OPCODE/flagbit/IMM         head instruction fields (zero when empty)
//   instr_pc                   address the head was fetched from
module instr_prefetch_queue
  import instr_prefetch_queue_pkg::*;
#(
  parameter int              ADDR_W     = 16,
  parameter int              DEPTH      = 4,
  parameter logic [ADDR_W-1:0] RESET_ADDR = '0
) (
  input  logic              CLK,
  input  logic              Reset_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic              flush,
  input  logic [ADDR_W-1:0] flush_addr,
  output logic              instr_ready,
  input  logic              instr_take,
  output logic [OP_MSB-OP_LSB:0] OPCODE,
  output logic              flagbit,
  output logic [IMM_W-1:0]  IMM,
  output logic [ADDR_W-1:0] instr_pc
);

  localparam int CW      = $clog2(DEPTH) + 1;
  localparam int ENTRY_W = INSTR_W + ADDR_W;

  fetch_state_e        state_q, state_d;
  logic [ADDR_W-1:0]   fetch_addr_q, fetch_addr_d;
  logic [ADDR_W-1:0]   inflight_addr_q, inflight_addr_d;
  logic [CW-1:0]       count;
  logic [ENTRY_W-1:0]  head;
  logic [INSTR_W-1:0]  head_word;
  logic                issue, push, pop;

  // Only one request is ever outstanding and it is only issued from IDLE, so
  // count < DEPTH here is enough to guarantee room for the response.
  // Reset_n gates the pulse so nothing is requested while reset is held.
  assign issue = (state_q == ST_IDLE) && (count < CW'(DEPTH)) && !flush && Reset_n;
  assign push  = (state_q == ST_WAIT) && imem_rvalid && !flush;
  assign pop   = instr_take && (count != '0) && !flush;

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q         <= ST_IDLE;
      fetch_addr_q    <= RESET_ADDR;
      inflight_addr_q <= '0;
    end else begin
      state_q         <= state_d;
      fetch_addr_q    <= fetch_addr_d;
      inflight_addr_q <= inflight_addr_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    fetch_addr_d    = fetch_addr_q;
    inflight_addr_d = inflight_addr_q;
    if (flush) begin
      fetch_addr_d = flush_addr;
      // A fetch still in flight must be swallowed when it eventually returns.
      if (state_q != ST_IDLE) state_d = imem_rvalid ? ST_IDLE : ST_DROP;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (issue) begin
            state_d         = ST_WAIT;
            inflight_addr_d = fetch_addr_q;
            fetch_addr_d    = fetch_addr_q + ADDR_W'(1);
          end
        end
        ST_WAIT: if (imem_rvalid) state_d = ST_IDLE;
        ST_DROP: if (imem_rvalid) state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  iq_fifo #(
    .DW    (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (CLK),
    .rst_ni  (Reset_n),
    .clear_i (flush),
    .push_i  (push),
    .wdata_i ({imem_rdata, inflight_addr_q}),
    .pop_i   (pop),
    .head_o  (head),
    .count_o (count)
  );

  assign imem_req    = issue;
  assign imem_addr   = fetch_addr_q;
  assign instr_ready = (count != '0);
  assign head_word   = head[ENTRY_W-1:ADDR_W];
  assign instr_pc    = head[ADDR_W-1:0];
  assign OPCODE      = head_word[OP_MSB:OP_LSB];
  assign flagbit     = head_word[FLAG_BIT];
  assign IMM         = head_word[IMM_W-1:0];

endmodule

// File: tb/tb_instr_prefetch_queue.sv
module tb_instr_prefetch_queue;

  localparam int DEPTH = 4;

  logic        CLK;
  logic        Reset_n;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_rvalid;
  logic [15:0] imem_rdata;
  logic        flush;
  logic [15:0] flush_addr;
  logic        instr_ready;
  logic        instr_take;
  logic [4:0]  OPCODE;
  logic        flagbit;
  logic [9:0]  IMM;
  logic [15:0] instr_pc;

  instr_prefetch_queue #(.ADDR_W(16), .DEPTH(DEPTH), .RESET_ADDR(16'h0000)) dut (
    .CLK         (CLK),
    .Reset_n     (Reset_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .flush       (flush),
    .flush_addr  (flush_addr),
    .instr_ready (instr_ready),
    .instr_take  (instr_take),
    .OPCODE      (OPCODE),
    .flagbit     (flagbit),
    .IMM         (IMM),
    .instr_pc    (instr_pc)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] data;
  } ent_t;

  int n_checks = 0;
  int n_errors = 0;

  // reference model: queue contents plus fetch bookkeeping
  ent_t        mq[$];
  logic [15:0] m_fetch = 16'h0000;
  logic [15:0] m_pend  = 16'h0000;
  bit          m_busy  = 0;
  bit          m_drop  = 0;

  // memory responder
  int          lat      = 1;
  bit          mem_pend = 0;
  int          mem_cnt  = 0;
  logic [15:0] mem_addr = 16'h0000;
  int          n_req    = 0;

  // values sampled in the most recent cycle
  bit          s_req, s_ready;
  logic [15:0] s_addr, s_pc;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    logic [15:0] w;
    w = 16'(a * 16'h9E37) ^ 16'h3C5A;
    if (a == 16'h0000) w = 16'h5400;
    return w;
  endfunction

  task automatic cycle(input bit fl, input logic [15:0] fa, input bit tk);
    bit          rv, exp_req;
    logic [15:0] rd;
    ent_t        h;
    @(negedge CLK);
    rv = mem_pend && (mem_cnt == 0);
    rd = rv ? mem_word(mem_addr) : 16'h0000;
    flush       = fl;
    flush_addr  = fa;
    instr_take  = tk;
    imem_rvalid = rv;
    imem_rdata  = rd;
    #1;
    exp_req = !m_busy && (mq.size() < DEPTH) && !fl;
    h = (mq.size() > 0) ? mq[0] : '0;
    check_eq("req", 32'(imem_req), 32'(exp_req));
    if (exp_req) check_eq("req_addr", 32'(imem_addr), 32'(m_fetch));
    check_eq("ready", 32'(instr_ready), 32'(mq.size() > 0));
    check_eq("opcode", 32'(OPCODE), 32'(h.data[15:11]));
    check_eq("flagbit", 32'(flagbit), 32'(h.data[10]));
    check_eq("imm", 32'(IMM), 32'(h.data[9:0]));
    check_eq("pc", 32'(instr_pc), 32'(h.pc));
    s_req = imem_req; s_addr = imem_addr; s_ready = instr_ready; s_pc = instr_pc;
    // clock-edge effect on the model
    if (fl) begin
      mq.delete();
      m_fetch = fa;
      if (m_busy) begin
        if (rv) begin m_busy = 0; m_drop = 0; end
        else m_drop = 1;
      end
    end else begin
      if (tk && mq.size() > 0) void'(mq.pop_front());
      if (m_busy) begin
        if (rv) begin
          if (!m_drop) mq.push_back('{pc: m_pend, data: rd});
          m_busy = 0;
          m_drop = 0;
        end
      end else if (exp_req) begin
        m_busy  = 1;
        m_pend  = m_fetch;
        m_fetch = m_fetch + 16'd1;
      end
    end
    // memory responder follows the DUT's actual request
    if (rv) mem_pend = 0;
    else if (mem_pend && mem_cnt > 0) mem_cnt--;
    if (imem_req) begin
      mem_pend = 1;
      mem_cnt  = lat - 1;
      mem_addr = imem_addr;
      n_req++;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit          done, saw_wrap;
    logic [15:0] exp_seq;
    int          n_pop;

    Reset_n = 0; flush = 0; flush_addr = 0; instr_take = 0;
    imem_rvalid = 0; imem_rdata = 0;
    repeat (2) @(negedge CLK);
    #1;
    check_eq("rst_req", 32'(imem_req), 0);
    check_eq("rst_ready", 32'(instr_ready), 0);
    check_eq("rst_fields", 32'({OPCODE, flagbit, IMM}), 0);
    check_eq("rst_pc", 32'(instr_pc), 0);
    @(posedge CLK); #2 Reset_n = 1;

    // fill with latency 1, no takes: 4 requests then stall
    lat = 1;
    repeat (12) cycle(0, 16'h0, 0);
    check_eq("fill_req_count", 32'(n_req), 4);
    check_eq("fill_no_req", 32'(s_req), 0);
    check_eq("fill_ready", 32'(s_ready), 1);
    check_eq("head0_opcode", 32'(OPCODE), 32'd10);
    check_eq("head0_flag", 32'(flagbit), 1);
    check_eq("head0_imm", 32'(IMM), 0);
    check_eq("head0_pc", 32'(instr_pc), 0);
    cycle(0, 16'h0, 1);
    cycle(0, 16'h0, 0);
    check_eq("pc_after_take", 32'(s_pc), 1);

    // latency 3, flush to 0x40 while a fetch is outstanding
    lat = 3;
    done = 0;
    for (int i = 0; i < 30 && !done; i++) begin
      if (mem_pend && mem_cnt > 0) begin
        cycle(1, 16'h0040, 0);
        done = 1;
      end else cycle(0, 16'h0, 1);
    end
    check_eq("flush_wait_found", 32'(done), 1);
    cycle(0, 16'h0, 0);
    check_eq("flush_ready_low", 32'(s_ready), 0);
    done = 0;
    for (int i = 0; i < 10 && !done; i++) begin
      if (s_req) begin
        check_eq("flush_redirect_addr", 32'(s_addr), 32'h40);
        done = 1;
      end else cycle(0, 16'h0, 0);
    end
    check_eq("flush_req_seen", 32'(done), 1);
    repeat (10) cycle(0, 16'h0, 0);
    check_eq("flush_head_pc", 32'(s_pc), 32'h40);

    // flush, rvalid and take in the same cycle
    lat = 1;
    done = 0;
    for (int i = 0; i < 30 && !done; i++) begin
      if (mem_pend && mem_cnt == 0 && mq.size() > 0) begin
        cycle(1, 16'h1234, 1);
        done = 1;
      end else cycle(0, 16'h0, 0);
    end
    check_eq("triple_found", 32'(done), 1);
    cycle(0, 16'h0, 0);
    check_eq("triple_empty", 32'(s_ready), 0);
    check_eq("triple_req", 32'(s_req), 1);
    check_eq("triple_addr", 32'(s_addr), 32'h1234);

    // continuous take across the address wrap
    cycle(1, 16'hFFFD, 0);
    exp_seq = 16'hFFFD; saw_wrap = 0; n_pop = 0;
    repeat (30) begin
      cycle(0, 16'h0, 1);
      if (s_ready) begin
        check_eq("wrap_seq", 32'(s_pc), 32'(exp_seq));
        if (s_pc == 16'h0000) saw_wrap = 1;
        exp_seq = exp_seq + 16'd1;
        n_pop++;
      end
    end
    check_eq("wrap_seen", 32'(saw_wrap), 1);
    check_eq("wrap_pops_min", 32'(n_pop >= 8), 1);

    // reset while a fetch is outstanding; the late response must be ignored
    lat = 3;
    done = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      if (mem_pend && mem_cnt > 0) done = 1;
      else cycle(0, 16'h0, 0);
    end
    check_eq("rst_wait_found", 32'(done), 1);
    @(negedge CLK);
    Reset_n = 0; flush = 0; instr_take = 0; imem_rvalid = 0;
    #1;
    check_eq("midrst_req", 32'(imem_req), 0);
    check_eq("midrst_ready", 32'(instr_ready), 0);
    check_eq("midrst_fields", 32'({OPCODE, flagbit, IMM}), 0);
    check_eq("midrst_pc", 32'(instr_pc), 0);
    mq.delete(); m_fetch = 16'h0000; m_busy = 0; m_drop = 0;
    mem_cnt = 0;
    @(posedge CLK); #2 Reset_n = 1;
    cycle(0, 16'h0, 0);
    check_eq("stray_req", 32'(s_req), 1);
    check_eq("stray_addr", 32'(s_addr), 0);
    cycle(0, 16'h0, 0);
    check_eq("stray_ignored", 32'(s_ready), 0);

    // randomized traffic
    for (int i = 0; i < 2500; i++) begin
      bit          fl;
      logic [15:0] fa;
      if (i % 40 == 0) lat = $urandom_range(1, 4);
      fl = ($urandom_range(0, 19) == 0);
      fa = $urandom_range(0, 1) ? 16'($urandom) : 16'(16'hFFFC + $urandom_range(0, 3));
      cycle(fl, fa, $urandom_range(0, 9) < 6);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
